// File: rtl/daa_io_pkg.sv
// Shared definitions for the user-project pad engines (transmit and receive paths).
package daa_io_pkg;

    localparam int PAD_TX_W    = 10;
    localparam int TX_STB_BIT  = 8;
    localparam int TX_LAST_BIT = 9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } tx_state_e;

endpackage

// File: rtl/daa_sync_fifo.sv
// Single-clock word FIFO; an empty FIFO forwards a same-cycle push straight to the read side.
module daa_sync_fifo
    import daa_io_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         rd_valid_o,
    output logic         empty_o,
    output logic         not_full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          not_full_r;
    logic          empty_s;

    assign empty_s    = (count_r == {CW{1'b0}});
    assign empty_o    = empty_s;
    assign not_full_o = not_full_r;
    assign rd_valid_o = !empty_s || push_i;
    assign rd_data_o  = empty_s ? wr_data_i : mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop (a bypassed word leaves it unchanged)
    always_comb begin
        count_next_s = count_r;
        case ({push_i, pop_i})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    // Pointers, occupancy and the registered room flag (held low through reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            not_full_r <= 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_i) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r    <= count_next_s;
            not_full_r <= (count_next_s != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/daa_io_pad_tx.sv
// Transmit pad engine: buffered words go out byte-serial, LSB-first, on a strobe/ack toggle handshake.
module daa_io_pad_tx
    import daa_io_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [DATA_W-1:0]   s_data_i,
    input  logic                s_last_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic                tx_en_i,
    input  logic                host_ack_i,
    output logic [PAD_TX_W-1:0] io_out_o,
    output logic [PAD_TX_W-1:0] io_oeb_o,
    output logic                busy_o,
    output logic                proto_err_o
);

    localparam int NBYTE = DATA_W / 8;
    localparam int NBW   = $clog2(NBYTE + 1);
    localparam int CNTW  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    logic [DATA_W:0]     fifo_rd_data_s;
    logic                fifo_rd_valid_s;
    logic                fifo_empty_s;
    logic                fifo_not_full_s;
    logic                push_s;
    logic                pop_s;
    logic                ack_match_s;
    logic                word_done_s;
    logic [DATA_W-1:0]   next_shift_s;
    logic [PAD_TX_W-1:0] pad_s;

    tx_state_e           state_r;
    logic [DATA_W-1:0]   shift_r;
    logic [NBW-1:0]      nbyte_r;
    logic [CNTW-1:0]     setup_cnt_r;
    logic                word_last_r;
    logic [7:0]          byte_r;
    logic                strobe_r;
    logic                last_r;
    logic                ack_meta_r;
    logic                ack_sync_r;
    logic                ack_prev_r;
    logic                proto_err_r;
    logic                tx_en_r;

    daa_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .push_i     (push_s),
        .wr_data_i  ({s_last_i, s_data_i}),
        .pop_i      (pop_s),
        .rd_data_o  (fifo_rd_data_s),
        .rd_valid_o (fifo_rd_valid_s),
        .empty_o    (fifo_empty_s),
        .not_full_o (fifo_not_full_s)
    );

    assign push_s       = s_valid_i && fifo_not_full_s;
    assign s_ready_o    = fifo_not_full_s;
    assign ack_match_s  = (ack_sync_r == strobe_r);
    assign word_done_s  = ack_match_s && (nbyte_r == NBW'(1'b1));
    assign next_shift_s = shift_r >> 4'd8;
    assign busy_o       = !fifo_empty_s || (state_r != IDLE);
    assign proto_err_o  = proto_err_r;
    assign io_oeb_o     = tx_en_r ? {PAD_TX_W{1'b0}} : {PAD_TX_W{1'b1}};

    // Pad word assembled from registered byte, strobe and last flag
    always_comb begin
        pad_s              = {PAD_TX_W{1'b0}};
        pad_s[7:0]         = byte_r;
        pad_s[TX_STB_BIT]  = strobe_r;
        pad_s[TX_LAST_BIT] = last_r;
    end
    assign io_out_o = pad_s;

    // A word is taken from the FIFO when idle, or straight after the last byte of the current word
    always_comb begin
        pop_s = 1'b0;
        if (tx_en_i && fifo_rd_valid_s) begin
            case (state_r)
                IDLE:     pop_s = 1'b1;
                WAIT_ACK: pop_s = word_done_s;
                default:  pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Ack synchroniser, edge history, sticky protocol error and pad-enable register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_meta_r  <= 1'b0;
            ack_sync_r  <= 1'b0;
            ack_prev_r  <= 1'b0;
            proto_err_r <= 1'b0;
            tx_en_r     <= 1'b0;
        end else begin
            ack_meta_r <= host_ack_i;
            ack_sync_r <= ack_meta_r;
            ack_prev_r <= ack_sync_r;
            tx_en_r    <= tx_en_i;
            if ((ack_sync_r != ack_prev_r) && (state_r != WAIT_ACK)) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Byte sequencer; frozen entirely while tx_en_i is low
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= IDLE;
            shift_r     <= {DATA_W{1'b0}};
            nbyte_r     <= {NBW{1'b0}};
            setup_cnt_r <= {CNTW{1'b0}};
            word_last_r <= 1'b0;
            byte_r      <= 8'h00;
            strobe_r    <= 1'b0;
            last_r      <= 1'b0;
        end else if (tx_en_i) begin
            if (pop_s) begin
                shift_r     <= fifo_rd_data_s[DATA_W-1:0];
                word_last_r <= fifo_rd_data_s[DATA_W];
                byte_r      <= fifo_rd_data_s[7:0];
                last_r      <= fifo_rd_data_s[DATA_W] && (NBYTE == 1);
                nbyte_r     <= NBW'(NBYTE);
                setup_cnt_r <= {CNTW{1'b0}};
                state_r     <= SETUP;
            end else begin
                case (state_r)
                    IDLE: state_r <= IDLE;
                    SETUP: begin
                        if (setup_cnt_r == CNTW'(SETUP_CYC - 1)) begin
                            strobe_r <= ~strobe_r;
                            state_r  <= WAIT_ACK;
                        end else begin
                            setup_cnt_r <= setup_cnt_r + CNTW'(1'b1);
                        end
                    end
                    WAIT_ACK: begin
                        if (word_done_s) begin
                            state_r <= IDLE;
                        end else if (ack_match_s) begin
                            shift_r     <= next_shift_s;
                            byte_r      <= next_shift_s[7:0];
                            last_r      <= word_last_r && (nbyte_r == NBW'(2'd2));
                            nbyte_r     <= nbyte_r - NBW'(1'b1);
                            setup_cnt_r <= {CNTW{1'b0}};
                            state_r     <= SETUP;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daa_io_pad_tx.sv
// Bench for daa_io_pad_tx: a host model acks strobes and checks each byte against an expected byte stream.
module tb_daa_io_pad_tx;
    import daa_io_pkg::*;

    localparam int DW = 16;
    localparam int NB = DW / 8;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_ni = 1'b0;
    logic [DW-1:0]       s_data_i = '0;
    logic                s_last_i = 1'b0;
    logic                s_valid_i = 1'b0;
    logic                s_ready_o;
    logic                tx_en_i = 1'b0;
    logic                host_ack_i = 1'b0;
    logic [PAD_TX_W-1:0] io_out_o;
    logic [PAD_TX_W-1:0] io_oeb_o;
    logic                busy_o;
    logic                proto_err_o;

    daa_io_pad_tx #(.DATA_W(DW), .FIFO_DEPTH(4), .SETUP_CYC(1)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .tx_en_i     (tx_en_i),
        .host_ack_i  (host_ack_i),
        .io_out_o    (io_out_o),
        .io_oeb_o    (io_oeb_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_mem [1024];
    logic [8:0] obs_mem [1024];
    int wr_idx = 0;
    int rd_idx = 0;
    int obs_idx = 0;
    int base = 0;
    logic seen_stb = 1'b0;
    logic [8:0] held_val = 9'h000;
    int pend = -1;
    int ack_delay = 3;
    bit rand_delay = 1'b0;
    logic [PAD_TX_W-1:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] pad_val();
        return {io_out_o[TX_LAST_BIT], io_out_o[7:0]};
    endfunction

    // Expected pad bytes of one word: LSB byte first, last flag only on the final byte of a last word
    task automatic push_model(input logic [DW-1:0] d, input logic l);
        for (int b = 0; b < NB; b++) begin
            exp_mem[wr_idx % 1024] = {l && (b == NB - 1), d[8*b +: 8]};
            wr_idx++;
        end
    endtask

    // One clock: per-cycle output checks plus the host side of the handshake
    task automatic tick();
        logic tx_at_edge;
        tx_at_edge = tx_en_i && wb_rst_ni;
        @(negedge wb_clk_i);
        chk("oeb", 32'(io_oeb_o), 32'(tx_at_edge ? 10'h000 : 10'h3FF));
        if (!wb_rst_ni) begin
            rd_idx = wr_idx;
            seen_stb = 1'b0;
            held_val = 9'h000;
            pend = -1;
            host_ack_i = 1'b0;
            prev_out = io_out_o;
            return;
        end
        if (!tx_at_edge) chk("frozen", 32'(io_out_o), 32'(prev_out));
        if (io_out_o[TX_STB_BIT] != seen_stb) begin
            seen_stb = io_out_o[TX_STB_BIT];
            held_val = pad_val();
            obs_mem[obs_idx % 1024] = held_val;
            obs_idx++;
            if (rd_idx == wr_idx) begin
                chk("byte_pending", 32'(wr_idx - rd_idx), 32'(1));
            end else begin
                chk("byte", 32'(held_val), 32'(exp_mem[rd_idx % 1024]));
                rd_idx++;
            end
            pend = rand_delay ? int'($urandom_range(0, 15)) : ack_delay;
        end else if (seen_stb != host_ack_i) begin
            chk("hold", 32'(pad_val()), 32'(held_val));
        end
        if (pend == 0) begin
            host_ack_i = seen_stb;
            pend = -1;
        end else if (pend > 0) begin
            pend--;
        end
        prev_out = io_out_o;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        s_data_i = d;
        s_last_i = l;
        s_valid_i = 1'b1;
        while (!acc && waited < 400) begin
            acc = s_ready_o;
            if (acc) push_model(d, l);
            tick();
            waited++;
        end
        s_valid_i = 1'b0;
        chk("accept", 32'(acc), 32'(1));
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((rd_idx != wr_idx || busy_o) && n < lim) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(wr_idx - rd_idx), 32'(0));
        chk("drain_busy", 32'(busy_o), 32'(0));
    endtask

    function automatic logic [8:0] obs(input int k);
        return obs_mem[(base + k) % 1024];
    endfunction

    initial begin
        int n;
        logic stb_before;

        repeat (3) tick();
        chk("rst_out", 32'(io_out_o), 32'(0));
        chk("rst_ready", 32'(s_ready_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_err", 32'(proto_err_o), 32'(0));
        wb_rst_ni = 1'b1;
        tx_en_i = 1'b1;
        repeat (2) tick();
        chk("ready_up", 32'(s_ready_o), 32'(1));
        chk("oeb_en", 32'(io_oeb_o), 32'(10'h000));

        // Single word with first-byte latency pinned
        ack_delay = 3;
        base = obs_idx;
        s_data_i = 16'hBEEF;
        s_last_i = 1'b1;
        s_valid_i = 1'b1;
        chk("ready_single", 32'(s_ready_o), 32'(1));
        push_model(16'hBEEF, 1'b1);
        tick();
        s_valid_i = 1'b0;
        chk("lat_byte", 32'(io_out_o[7:0]), 32'(8'hEF));
        chk("lat_stb_low", 32'(io_out_o[TX_STB_BIT]), 32'(0));
        chk("busy_run", 32'(busy_o), 32'(1));
        tick();
        chk("lat_stb_tog", 32'(io_out_o[TX_STB_BIT]), 32'(1));
        drain(200);
        chk("beef_b0", 32'(obs(0)), 32'(9'h0EF));
        chk("beef_b1", 32'(obs(1)), 32'(9'h1BE));

        // Back-to-back words with a slow host: one word in flight plus four buffered
        ack_delay = 20;
        base = obs_idx;
        for (int i = 0; i < 5; i++) send(16'hA050 + 16'(i) * 16'h0101, i[0]);
        chk("ready_full", 32'(s_ready_o), 32'(0));
        repeat (5) tick();
        chk("ready_full_hold", 32'(s_ready_o), 32'(0));
        send(16'hA555, 1'b1);
        drain(1500);
        chk("b2b_first", 32'(obs(0)), 32'(9'h050));
        chk("b2b_w0_hi", 32'(obs(1)), 32'(9'h0A0));
        chk("b2b_w1_hi", 32'(obs(3)), 32'(9'h1A1));
        chk("b2b_last", 32'(obs(11)), 32'(9'h1A5));

        // Freeze while waiting for an ack
        ack_delay = 30;
        base = obs_idx;
        send(16'h5AA5, 1'b1);
        n = 0;
        while (io_out_o[TX_STB_BIT] == host_ack_i && n < 20) begin
            tick();
            n++;
        end
        chk("wait_ack_reached", 32'(io_out_o[TX_STB_BIT] != host_ack_i), 32'(1));
        stb_before = io_out_o[TX_STB_BIT];
        tx_en_i = 1'b0;
        repeat (10) tick();
        chk("freeze_oeb", 32'(io_oeb_o), 32'(10'h3FF));
        chk("freeze_stb", 32'(io_out_o[TX_STB_BIT]), 32'(stb_before));
        chk("freeze_busy", 32'(busy_o), 32'(1));
        tx_en_i = 1'b1;
        drain(400);
        chk("freeze_b0", 32'(obs(0)), 32'(9'h0A5));
        chk("freeze_b1", 32'(obs(1)), 32'(9'h15A));

        // Spurious host ack while idle
        chk("err_clear", 32'(proto_err_o), 32'(0));
        host_ack_i = ~host_ack_i;
        repeat (5) tick();
        chk("err_set", 32'(proto_err_o), 32'(1));
        host_ack_i = ~host_ack_i;
        repeat (5) tick();
        ack_delay = 2;
        base = obs_idx;
        send(16'h1234, 1'b0);
        drain(200);
        chk("err_sticky", 32'(proto_err_o), 32'(1));
        chk("spur_b0", 32'(obs(0)), 32'(9'h034));
        chk("spur_b1", 32'(obs(1)), 32'(9'h012));

        // Reset in the middle of a transfer
        ack_delay = 25;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        send(16'h3333, 1'b0);
        repeat (5) tick();
        wb_rst_ni = 1'b0;
        #1;
        chk("mid_rst_oeb", 32'(io_oeb_o), 32'(10'h3FF));
        chk("mid_rst_out", 32'(io_out_o), 32'(0));
        chk("mid_rst_ready", 32'(s_ready_o), 32'(0));
        chk("mid_rst_busy", 32'(busy_o), 32'(0));
        chk("mid_rst_err", 32'(proto_err_o), 32'(0));
        repeat (2) tick();
        wb_rst_ni = 1'b1;
        repeat (2) tick();
        chk("post_rst_ready", 32'(s_ready_o), 32'(1));
        ack_delay = 2;
        base = obs_idx;
        send(16'hC0DE, 1'b1);
        drain(200);
        chk("post_rst_b0", 32'(obs(0)), 32'(9'h0DE));
        chk("post_rst_b1", 32'(obs(1)), 32'(9'h1C0));

        // Random words and random host ack delays
        rand_delay = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send(16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(2000);
        chk("final_err", 32'(proto_err_o), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
